// File: rtl/vu_pkg.sv
// Shared sizes, FSM state type and saturating arithmetic for the VU meter frame scheduler.
package vu_pkg;
    localparam int NUM_BANDS = 16;
    localparam int LEVEL_W   = 8;
    localparam int BAR_W     = NUM_BANDS * LEVEL_W;
    localparam int HCNT_W    = 6;
    localparam int IDX_W     = $clog2(NUM_BANDS);

    typedef enum logic {
        ACCUM,
        COMMIT
    } state_t;

    function automatic logic [LEVEL_W-1:0] sat0(input logic [LEVEL_W-1:0] a,
                                                input logic [LEVEL_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction
endpackage

// File: rtl/vu_band_update.sv
// Per-band frame update: decays the bar towards the frame peak and runs the peak-hold timer.
module vu_band_update
    import vu_pkg::*;
#(
    parameter logic [LEVEL_W-1:0] DECAY_STEP  = 8'd4,
    parameter logic [HCNT_W-1:0]  HOLD_FRAMES = 6'd30
) (
    input  logic [LEVEL_W-1:0] frame_peak,
    input  logic [LEVEL_W-1:0] bar,
    input  logic [LEVEL_W-1:0] hold,
    input  logic [HCNT_W-1:0]  hcnt,
    output logic [LEVEL_W-1:0] bar_next,
    output logic [LEVEL_W-1:0] hold_next,
    output logic [HCNT_W-1:0]  hcnt_next
);
    logic [LEVEL_W-1:0] bar_decayed;

    always_comb begin
        bar_decayed = sat0(bar, DECAY_STEP);
        bar_next    = (frame_peak > bar_decayed) ? frame_peak : bar_decayed;
        hold_next   = hold;
        hcnt_next   = hcnt;
        if (bar_next >= hold) begin
            hold_next = bar_next;
            hcnt_next = HOLD_FRAMES;
        end else if (hcnt != '0) begin
            hcnt_next = hcnt - HCNT_W'(1);
        end else begin
            hold_next = sat0(hold, DECAY_STEP);
        end
    end
endmodule

// File: rtl/vu_frame_ctrl.sv
// Frame-synchronous VU level scheduler: accumulates per-band peaks, commits
// decayed bars and peak-hold markers one band per cycle after each vsync edge.
module vu_frame_ctrl
    import vu_pkg::*;
#(
    parameter int   DECAY_STEP   = 4,
    parameter int   HOLD_FRAMES  = 30,
    parameter logic VSYNC_ACTIVE = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               v_sync,
    input  logic               sample_valid,
    input  logic [3:0]         sample_band,
    input  logic [LEVEL_W-1:0] sample_level,
    output logic               sample_ready,
    output logic [BAR_W-1:0]   bar_data,
    output logic [BAR_W-1:0]   peak_data,
    output logic               bar_strobe,
    output logic               overrun
);
    state_t             state, state_next;
    logic [IDX_W-1:0]   idx;
    logic               vs_q;
    logic               sync_edge;
    logic               last_band;
    logic [LEVEL_W-1:0] frame_peak [NUM_BANDS];
    logic [LEVEL_W-1:0] bar_sh     [NUM_BANDS];
    logic [LEVEL_W-1:0] hold_sh    [NUM_BANDS];
    logic [HCNT_W-1:0]  hcnt       [NUM_BANDS];
    logic [LEVEL_W-1:0] bar_next, hold_next;
    logic [HCNT_W-1:0]  hcnt_next;
    logic [BAR_W-1:0]   bar_word, peak_word;

    assign sync_edge = (vs_q != VSYNC_ACTIVE) && (v_sync == VSYNC_ACTIVE);
    assign last_band = (idx == IDX_W'(NUM_BANDS - 1));

    vu_band_update #(
        .DECAY_STEP  (LEVEL_W'(DECAY_STEP)),
        .HOLD_FRAMES (HCNT_W'(HOLD_FRAMES))
    ) u_band_update (
        .frame_peak (frame_peak[idx]),
        .bar        (bar_sh[idx]),
        .hold       (hold_sh[idx]),
        .hcnt       (hcnt[idx]),
        .bar_next   (bar_next),
        .hold_next  (hold_next),
        .hcnt_next  (hcnt_next)
    );

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (sync_edge) state_next = COMMIT;
            COMMIT:  if (last_band) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // The last band's fresh result is spliced in so it lands in the same word load as the shadows.
    always_comb begin
        bar_word  = '0;
        peak_word = '0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            bar_word[b*LEVEL_W +: LEVEL_W]  = bar_sh[b];
            peak_word[b*LEVEL_W +: LEVEL_W] = hold_sh[b];
        end
        bar_word[(NUM_BANDS-1)*LEVEL_W +: LEVEL_W]  = bar_next;
        peak_word[(NUM_BANDS-1)*LEVEL_W +: LEVEL_W] = hold_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ACCUM;
            idx          <= '0;
            vs_q         <= ~VSYNC_ACTIVE;
            sample_ready <= 1'b0;
            bar_data     <= '0;
            peak_data    <= '0;
            bar_strobe   <= 1'b0;
            overrun      <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                frame_peak[b] <= '0;
                bar_sh[b]     <= '0;
                hold_sh[b]    <= '0;
                hcnt[b]       <= '0;
            end
        end else begin
            state      <= state_next;
            vs_q       <= v_sync;
            bar_strobe <= 1'b0;
            if (state == ACCUM) begin
                // A 4-bit band index always addresses one of the 16 bands.
                if (sample_valid && sample_ready && (sample_level > frame_peak[sample_band]))
                    frame_peak[sample_band] <= sample_level;
                idx          <= '0;
                sample_ready <= !sync_edge;
            end else begin
                if (sync_edge)
                    overrun <= 1'b1;
                bar_sh[idx]     <= bar_next;
                hold_sh[idx]    <= hold_next;
                hcnt[idx]       <= hcnt_next;
                frame_peak[idx] <= '0;
                idx             <= idx + IDX_W'(1);
                if (last_band) begin
                    bar_data     <= bar_word;
                    peak_data    <= peak_word;
                    bar_strobe   <= 1'b1;
                    sample_ready <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/vu_frame_ctrl.md
# vu_frame_ctrl

Frame-synchronous level scheduler for the VU meter display path. Accepts per-band audio level samples over a valid/ready handshake, tracks the per-frame peak of each band, and at the start of each vertical sync pulse commits decayed bar heights and peak-hold markers as packed 128-bit words. These words drive `data_in` of `vga_sync`, so the displayed bars change only between frames and never tear mid-scan.

## Interface
- `NUM_BANDS`, 16: number of bars; fixed by the 128-bit display word (16 × 8).
- `LEVEL_W`, 8: bits per level.
- `DECAY_STEP`, 4: amount subtracted from bar and hold values per frame when falling.
- `HOLD_FRAMES`, 30: number of frames a peak marker is held before it starts decaying (≤ 63).
- `VSYNC_ACTIVE`, 1'b0: active level of `v_sync`; commit triggers on the transition into this level.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `v_sync`  in  1  vertical sync from `vga_sync`.
- `sample_valid`  in  1  sample present.
- `sample_band`  in  4  band index 0..15.
- `sample_level`  in  8  unsigned level.
- `sample_ready`  out  1  sample accepted when high together with `sample_valid`.
- `bar_data`  out  128  bar heights; band b is at [8b+7:8b].
- `peak_data`  out  128  peak-hold markers, packed like `bar_data`.
- `bar_strobe`  out  1  one-cycle pulse when `bar_data`/`peak_data` update.
- `overrun`  out  1  sticky; set if a sync edge arrives during COMMIT.

## Operation
- States: ACCUM, COMMIT. Reset enters ACCUM.
- ACCUM: on handshake, `frame_peak[band] <= max(frame_peak[band], sample_level)`.
- Sync edge: `v_sync` registered into `vs_q`. The edge is `vs_q != VSYNC_ACTIVE && v_sync == VSYNC_ACTIVE`, evaluated only in ACCUM. On an edge: go to COMMIT, `idx <= 0`, `sample_ready <= 0`.
- COMMIT processes one band per cycle (`idx` 0..15). For band b:
  - `bar_new = max(frame_peak[b], sat0(bar[b] - DECAY_STEP))`.
  - If `bar_new >= hold[b]`: `hold <= bar_new`, `hcnt <= HOLD_FRAMES`.
  - Else if `hcnt != 0`: `hcnt--`.
  - Else: `hold <= sat0(hold - DECAY_STEP)`.
  - Then `frame_peak[b] <= 0`.
- Results are written to shadow registers. At `idx == 15`, both output words load from the shadows (including band 15), `bar_strobe <= 1`, `sample_ready <= 1`, and the block returns to ACCUM.
- Arithmetic is 8-bit unsigned. `sat0` clamps underflow to 0. Additions cannot overflow.
- A sync edge during COMMIT is ignored (no restart) and sets `overrun`. Only reset clears `overrun`.
- A `sample_band` outside 0..NUM_BANDS-1 is accepted and discarded.

## Timing
- Reset values:
  - `sample_ready` = 0, `bar_data` = 0, `peak_data` = 0, `bar_strobe` = 0, `overrun` = 0.
  - All `frame_peak`, `hold`, and `hcnt` = 0. `vs_q` = inactive level.
- `sample_ready` is registered. It rises at the first clock edge after `rst` deasserts.
- Edge detected at posedge P0 → COMMIT at P1..P16 → `bar_data`, `peak_data`, and `bar_strobe` update at P16. Latency is 16 cycles; `sample_ready` is low for exactly 16 cycles.
- A sample handshaken at P0 (same cycle as the edge) belongs to the frame being committed.
- `bar_data` and `peak_data` are stable between strobes.
- Reset asserted mid-COMMIT aborts immediately. All state returns to reset values and no strobe is produced.

## Structure
- Package `vu_pkg`:
  - `NUM_BANDS`, `LEVEL_W`, `BAR_W = NUM_BANDS*LEVEL_W`.
  - State enum {ACCUM, COMMIT}.
  - `sat0` subtract function.
- Sub-module `vu_band_update` (combinational): inputs `frame_peak`, `bar`, `hold`, `hcnt`; outputs next `bar`, `hold`, `hcnt`. Instantiated once and time-shared by `idx`.

## Test plan
- Reset, then drive band 3 = 0x80 and band 3 = 0x40, then a sync edge → after 16 cycles `bar_data[31:24]` = 0x80, `peak_data[31:24]` = 0x80, all other bytes 0, one `bar_strobe`.
- No further samples after the first frame → `bar[3]` is 0x7C, 0x78, … on successive frames; `peak[3]` stays 0x80 for 30 frames, then 0x7C.
- Assert `sample_valid` continuously across a sync edge → `sample_ready` is low for exactly 16 cycles, no samples are lost, and the edge-cycle sample is included in the committed frame.
- Second sync edge 5 cycles after the first → commit completes normally with no restart, and `overrun` = 1 until reset.
- Assert `rst` at COMMIT `idx` = 7 → all outputs 0 immediately, no strobe; after release `sample_ready` = 1 one cycle later.
- Send `bar` = 0x02 with `DECAY_STEP` = 4 and no input → next frame `bar` = 0x00 (saturating, no wrap to 0xFE).
